fwd_hazard_ctrl: RTL and testbench

//  Forwarding/hazard controller for the 5-stage pipeline. Generates the 2-bit

---
 rtl/fwd_hazard_if.sv | 36 +++
 rtl/fwd_hazard_ctrl.sv | 117 +++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_if.sv
// Bundle between the 5-stage pipeline and its forwarding/hazard controller.
// The pipeline side (master) drives the ID/EX/MEM register indices and
// control bits. The controller side (slave) returns the operand selects,
// the stall and bubble controls and the stall-cycle counter.
interface fwd_hazard_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic              mem_memread;
    logic              mem_ready;
    logic [1:0]        fwd_a_sel;
    logic [1:0]        fwd_b_sel;
    logic              stall;
    logic              bubble;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_memread, mem_ready,
        input  fwd_a_sel, fwd_b_sel, stall, bubble, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, ex_rd, ex_regwrite, ex_memread,
               mem_rd, mem_regwrite, mem_memread, mem_ready,
        output fwd_a_sel, fwd_b_sel, stall, bubble, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding / hazard controller for the 5-stage pipeline.
// Produces the EX operand mux selects (registered alongside ID/EX), the
// IF/ID stall, the ID/EX bubble and a saturating stall-cycle counter.
// Select encoding: 0 regfile, 1 EX/MEM ALU, 2 MEM/WB ALU, 3 MEM/WB load data.
// Build option FWD_CTRL_BYPASS_EN: when defined, the forwarding paths are used
// and only load-use stalls; when undefined, selects stay 0 and any RAW
// dependency on EX or MEM stalls until the writer has retired.
module fwd_hazard_ctrl #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    fwd_hazard_if.slave bus
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        BUBBLE = 2'd1,
        WAIT   = 2'd2
    } state_t;

    state_t           state;
    logic             hit_ex_a, hit_ex_b, hit_mem_a, hit_mem_b;
    logic             hazard;
    logic             stall_c;
    logic [1:0]       sel_a_nxt, sel_b_nxt;
    logic [1:0]       sel_a_q, sel_b_q;
    logic             bubble_q;
    logic [CNT_W-1:0] cnt_q;

    // Source/destination matches; r0 is hard-wired zero and never matches.
    always_comb begin
        hit_ex_a  = bus.ex_regwrite  && (bus.ex_rd  == bus.id_rs) && (bus.id_rs != '0);
        hit_ex_b  = bus.ex_regwrite  && (bus.ex_rd  == bus.id_rt) && (bus.id_rt != '0);
        hit_mem_a = bus.mem_regwrite && (bus.mem_rd == bus.id_rs) && (bus.id_rs != '0);
        hit_mem_b = bus.mem_regwrite && (bus.mem_rd == bus.id_rt) && (bus.id_rt != '0);
    end

    // Hazard detection, stall and next operand selects.
`ifdef FWD_CTRL_BYPASS_EN
    always_comb begin
        // Only a load in EX cannot be bypassed: its data arrives from MEM.
        hazard    = bus.id_valid && bus.ex_memread && (hit_ex_a || hit_ex_b);
        stall_c   = !bus.mem_ready || ((state == RUN) && hazard);
        sel_a_nxt = 2'd0;
        sel_b_nxt = 2'd0;
        if (bus.id_valid) begin
            // EX is the youngest writer, so it wins over MEM.
            if (hit_ex_a)       sel_a_nxt = 2'd1;
            else if (hit_mem_a) sel_a_nxt = bus.mem_memread ? 2'd3 : 2'd2;
            if (hit_ex_b)       sel_b_nxt = 2'd1;
            else if (hit_mem_b) sel_b_nxt = bus.mem_memread ? 2'd3 : 2'd2;
        end
    end
`else
    always_comb begin
        // No bypass paths: wait until any in-flight writer reaches WB.
        hazard    = bus.id_valid && (hit_ex_a || hit_ex_b || hit_mem_a || hit_mem_b);
        stall_c   = !bus.mem_ready || hazard;
        sel_a_nxt = 2'd0;
        sel_b_nxt = 2'd0;
    end
`endif

    // Control FSM; bubble is registered and marks the cycle ID/EX holds a NOP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            bubble_q <= 1'b0;
        end else begin
`ifdef FWD_CTRL_BYPASS_EN
            bubble_q <= (state == RUN) && bus.mem_ready && hazard;
            case (state)
                RUN:     state <= !bus.mem_ready ? WAIT : (hazard ? BUBBLE : RUN);
                BUBBLE:  state <= !bus.mem_ready ? WAIT : RUN;
                WAIT:    state <= bus.mem_ready ? RUN : WAIT;
                default: state <= RUN;
            endcase
`else
            // Bubbles repeat while the dependency persists.
            bubble_q <= bus.mem_ready && hazard;
            case (state)
                RUN, BUBBLE: state <= !bus.mem_ready ? WAIT : (hazard ? BUBBLE : RUN);
                WAIT:        state <= !bus.mem_ready ? WAIT : (hazard ? BUBBLE : RUN);
                default:     state <= RUN;
            endcase
`endif
        end
    end

    // Operand selects advance with ID/EX and hold while the pipe is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_a_q <= 2'd0;
            sel_b_q <= 2'd0;
        end else if (!stall_c) begin
            sel_a_q <= sel_a_nxt;
            sel_b_q <= sel_b_nxt;
        end
    end

    // Stall-cycle counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (stall_c && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.fwd_a_sel = sel_a_q;
    assign bus.fwd_b_sel = sel_b_q;
    assign bus.stall     = stall_c;
    assign bus.bubble    = bubble_q;
    assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl. A table of per-cycle vectors is
// applied at the falling edge; stall is checked combinationally, the
// registered outputs just after the next rising edge. Hand sequences cover
// asynchronous reset mid-bubble and counter saturation on a 4-bit instance.
module tb_fwd_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    fwd_hazard_if #(.REG_AW(5), .CNT_W(16)) bm ();
    fwd_hazard_if #(.REG_AW(5), .CNT_W(4))  bs ();

    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bm.slave));
    fwd_hazard_ctrl #(.REG_AW(5), .CNT_W(4))  dut4 (.clk(clk), .rst_n(rst_n), .bus(bs.slave));

    assign bs.id_valid     = bm.id_valid;
    assign bs.id_rs        = bm.id_rs;
    assign bs.id_rt        = bm.id_rt;
    assign bs.ex_rd        = bm.ex_rd;
    assign bs.ex_regwrite  = bm.ex_regwrite;
    assign bs.ex_memread   = bm.ex_memread;
    assign bs.mem_rd       = bm.mem_rd;
    assign bs.mem_regwrite = bm.mem_regwrite;
    assign bs.mem_memread  = bm.mem_memread;
    assign bs.mem_ready    = bm.mem_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] rs, rt, exrd;
        logic       exw, exm;
        logic [4:0] memrd;
        logic       memw, memm, rdy;
        logic       e_st;
        logic [1:0] e_a, e_b;
        logic       e_bub;
        int         e_cnt;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(int v, int rs, int rt, int exrd, int exw, int exm,
                                int memrd, int memw, int memm, int rdy,
                                int st, int a, int b, int bub, int cnt);
        vec_t t;
        t.v = v[0]; t.rs = rs[4:0]; t.rt = rt[4:0]; t.exrd = exrd[4:0];
        t.exw = exw[0]; t.exm = exm[0]; t.memrd = memrd[4:0];
        t.memw = memw[0]; t.memm = memm[0]; t.rdy = rdy[0];
        t.e_st = st[0]; t.e_a = a[1:0]; t.e_b = b[1:0]; t.e_bub = bub[0];
        t.e_cnt = cnt;
        return t;
    endfunction

    task automatic drive(input vec_t t);
        bm.id_valid = t.v;      bm.id_rs = t.rs;         bm.id_rt = t.rt;
        bm.ex_rd = t.exrd;      bm.ex_regwrite = t.exw;  bm.ex_memread = t.exm;
        bm.mem_rd = t.memrd;    bm.mem_regwrite = t.memw; bm.mem_memread = t.memm;
        bm.mem_ready = t.rdy;
    endtask

    task automatic chk(input string nm, input int idx, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d, expected %0d", nm, idx, act, exp);
        end
    endtask

    // Idle pipeline with memory ready.
    function automatic vec_t idle(int rdy);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0, 0, 0, 0, 0);
    endfunction

    initial begin
        //        v rs rt exrd w m memrd w m rdy | st a b bub cnt
`ifdef FWD_CTRL_BYPASS_EN
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0)); // idle
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0)); // r0 never forwarded
        tbl.push_back(mk(1, 3, 0, 3, 1, 0, 0, 0, 0, 1,  0, 1, 0, 0, 0)); // ALU r3 in EX
        tbl.push_back(mk(1, 0, 6, 0, 0, 0, 6, 1, 0, 1,  0, 0, 2, 0, 0)); // ALU r6 in MEM
        tbl.push_back(mk(1, 0, 6, 0, 0, 0, 6, 1, 1, 1,  0, 0, 3, 0, 0)); // load r6 in MEM
        tbl.push_back(mk(1, 8, 8, 8, 1, 0, 8, 1, 1, 1,  0, 1, 1, 0, 0)); // EX beats MEM
        tbl.push_back(mk(1, 0, 5, 5, 1, 1, 5, 1, 0, 1,  1, 1, 1, 1, 1)); // load-use r5
        tbl.push_back(mk(1, 0, 5, 0, 0, 0, 5, 1, 1, 1,  0, 0, 3, 0, 1)); // leave BUBBLE
        tbl.push_back(mk(0, 3, 3, 3, 1, 0, 3, 1, 0, 1,  0, 0, 0, 0, 1)); // id_valid=0
        tbl.push_back(mk(1, 3, 0, 2, 1, 1, 0, 0, 0, 1,  0, 0, 0, 0, 1)); // load, no match
        tbl.push_back(mk(1, 3, 0, 3, 1, 0, 0, 0, 0, 1,  0, 1, 0, 0, 1)); // set sel_a=1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 2)); // mem wait 1
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 3)); // mem wait 2
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 4)); // mem wait 3
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 4)); // wait done
        tbl.push_back(mk(1, 4, 0, 4, 1, 1, 0, 0, 0, 0,  1, 0, 0, 0, 5)); // wait beats lu
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 5)); // back to RUN
        tbl.push_back(mk(1, 4, 0, 4, 1, 1, 0, 0, 0, 1,  1, 0, 0, 1, 6)); // load-use r4
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 6)); // leave BUBBLE
`else
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0)); // idle
        tbl.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 1,  0, 0, 0, 0, 0)); // r0 never matches
        tbl.push_back(mk(1, 3, 0, 3, 1, 0, 0, 0, 0, 1,  1, 0, 0, 1, 1)); // ALU r3 in EX
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 3, 1, 0, 1,  1, 0, 0, 1, 2)); // r3 now in MEM
        tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 2)); // r3 retired
        tbl.push_back(mk(1, 0, 7, 0, 0, 0, 7, 1, 0, 1,  1, 0, 0, 1, 3)); // rt hits MEM
        tbl.push_back(mk(0, 0, 7, 0, 0, 0, 7, 1, 0, 1,  0, 0, 0, 0, 3)); // id_valid=0
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 4)); // mem wait
        tbl.push_back(mk(1, 4, 0, 4, 1, 0, 0, 0, 0, 0,  1, 0, 0, 0, 5)); // wait beats hazard
        tbl.push_back(mk(1, 4, 0, 4, 1, 0, 0, 0, 0, 1,  1, 0, 0, 1, 6)); // hazard after wait
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 6)); // clean
        tbl.push_back(mk(1, 9, 0, 9, 0, 0, 0, 0, 0, 1,  0, 0, 0, 0, 6)); // no regwrite
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1,  0, 0, 0, 0, 6)); // r0 in MEM
`endif

        // Reset state.
        rst_n = 1'b0;
        drive(idle(1));
        #3;
        chk("rst_sel_a", 0, int'(bm.fwd_a_sel), 0);
        chk("rst_sel_b", 0, int'(bm.fwd_b_sel), 0);
        chk("rst_bubble", 0, int'(bm.bubble), 0);
        chk("rst_cnt", 0, int'(bm.stall_cnt), 0);
        chk("rst_stall", 0, int'(bm.stall), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of per-cycle vectors.
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i]);
            #1;
            chk("stall", i, int'(bm.stall), int'(tbl[i].e_st));
            @(posedge clk);
            #1;
            chk("sel_a", i, int'(bm.fwd_a_sel), int'(tbl[i].e_a));
            chk("sel_b", i, int'(bm.fwd_b_sel), int'(tbl[i].e_b));
            chk("bubble", i, int'(bm.bubble), int'(tbl[i].e_bub));
            chk("stall_cnt", i, int'(bm.stall_cnt), tbl[i].e_cnt);
        end

        // Asynchronous reset while the controller sits in BUBBLE.
`ifdef FWD_CTRL_BYPASS_EN
        @(negedge clk);
        drive(mk(1, 0, 6, 0, 0, 0, 6, 1, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("pre_sel_b", 0, int'(bm.fwd_b_sel), 3);
        @(negedge clk);
        drive(mk(1, 0, 5, 5, 1, 1, 6, 1, 1, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("pre_sel_b", 1, int'(bm.fwd_b_sel), 3);
        chk("pre_bubble", 1, int'(bm.bubble), 1);
        chk("pre_stall", 1, int'(bm.stall), 0); // BUBBLE does not re-stall
`else
        @(negedge clk);
        drive(mk(1, 3, 0, 3, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        chk("pre_bubble", 1, int'(bm.bubble), 1);
        chk("pre_cnt", 1, int'(bm.stall_cnt) == 0 ? 0 : 1, 1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_sel_a", 0, int'(bm.fwd_a_sel), 0);
        chk("arst_sel_b", 0, int'(bm.fwd_b_sel), 0);
        chk("arst_bubble", 0, int'(bm.bubble), 0);
        chk("arst_cnt", 0, int'(bm.stall_cnt), 0);
        // Hazard inputs still present: with state back in RUN, stall asserts.
        chk("arst_stall", 0, int'(bm.stall), 1);
        drive(idle(1));
        @(negedge clk);
        rst_n = 1'b1;

        // Twenty wait cycles: 16-bit counter reaches 20, 4-bit one sticks at 15.
        @(negedge clk);
        drive(idle(0));
        repeat (20) @(posedge clk);
        #1;
        chk("cnt16_20", 0, int'(bm.stall_cnt), 20);
        chk("cnt4_sat", 0, int'(bs.stall_cnt), 15);
        @(negedge clk);
        drive(idle(1));
        @(posedge clk); #1;
        chk("cnt16_hold", 0, int'(bm.stall_cnt), 20);
        chk("cnt4_hold", 0, int'(bs.stall_cnt), 15);
        chk("stall_idle", 0, int'(bm.stall), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
